keycode_cmd: RTL and testbench

Frame-synchronous motion-command generator between the Nios II `keycode` PIO export and the ball motion logic. It filters the raw 8-bit USB HID keycode for stability and turns W/A/S/D press and release changes into queued events. Once per video frame, on the rising edge of `vs`, it pops at most one event and presents a registered direction/moving command to the ball stage. Keys pressed faster than the frame rate are therefore applied in order rather than lost.

---
 rtl/keycode_pkg.sv | 39 +++
 rtl/keycode_cmd_if.sv | 15 +
 rtl/keycode_fifo.sv | 44 ++++
 rtl/keycode_cmd.sv | 109 ++++++++++
 tb/tb_keycode_cmd.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/keycode_pkg.sv
// Shared types and key constants for the W/A/S/D motion-command path.
// Maps HID usage codes onto queued move/stop events.
package keycode_pkg;

   typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

   localparam logic [7:0] KEY_W    = 8'h1A;
   localparam logic [7:0] KEY_A    = 8'h04;
   localparam logic [7:0] KEY_S    = 8'h16;
   localparam logic [7:0] KEY_D    = 8'h07;
   localparam logic [7:0] KEY_NONE = 8'h00;

   typedef struct packed {
      logic stop;
      dir_t dir;
   } kev_t;

   typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;

   function automatic logic key_is_event(input logic [7:0] code);
      return (code == KEY_W) || (code == KEY_A) || (code == KEY_S) ||
             (code == KEY_D) || (code == KEY_NONE);
   endfunction

   function automatic kev_t key_event(input logic [7:0] code);
      kev_t ev;
      ev.stop = 1'b0;
      ev.dir  = UP;
      case (code)
         KEY_S:    ev.dir  = DOWN;
         KEY_A:    ev.dir  = LEFT;
         KEY_D:    ev.dir  = RIGHT;
         KEY_NONE: ev.stop = 1'b1;
         default:  ;
      endcase
      return ev;
   endfunction

endpackage

// File: rtl/keycode_cmd_if.sv
// Keycode/frame inputs and per-frame motion command outputs of keycode_cmd.
interface keycode_cmd_if #(parameter int FIFO_DEPTH = 4);
   logic [7:0]                  keycode;
   logic                        frame_clk;
   logic [1:0]                  cmd_dir;
   logic                        cmd_moving;
   logic                        cmd_valid;
   logic [$clog2(FIFO_DEPTH):0] pending;
   logic                        overflow;

   modport master (output keycode, frame_clk,
                   input  cmd_dir, cmd_moving, cmd_valid, pending, overflow);
   modport slave  (input  keycode, frame_clk,
                   output cmd_dir, cmd_moving, cmd_valid, pending, overflow);
endinterface

// File: rtl/keycode_fifo.sv
// Small synchronous event FIFO; a pop frees a slot for a push in the same cycle.
module keycode_fifo
   import keycode_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  kev_t        din,
   output kev_t        dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);
   kev_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/keycode_cmd.sv
// Debounces the HID keycode, queues W/A/S/D/none changes as events and
// applies at most one event per video frame as a registered motion command.
module keycode_cmd
   import keycode_pkg::*;
#(
   parameter int STABLE_CYCLES = 1024,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   keycode_cmd_if.slave  bus
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

   logic [7:0]  cand, accepted;
   logic [15:0] cnt;
   logic        fire, push, pop, tick;
   logic        s1, s2, s3;
   logic        full, empty;
   logic [AW:0] count;
   kev_t        ev_in, ev_out;
   state_t      state_q, state_d;
   dir_t        dir_q, dir_d;
   logic        valid_q, ovf_q;

   // A code counts as settled once it has held for STABLE_CYCLES samples;
   // comparing against accepted makes each change fire exactly once.
   assign fire  = (cnt == CNT_MAX) && (cand != accepted);
   assign push  = fire & key_is_event(cand);
   assign ev_in = key_event(cand);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cand     <= KEY_NONE;
         accepted <= KEY_NONE;
         cnt      <= '0;
      end else begin
         if (bus.keycode != cand) begin
            cand <= bus.keycode;
            cnt  <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 16'd1;
         end
         if (fire) accepted <= cand;
      end
   end

   // Chain resets to the vs idle level so reset release cannot look like a rise.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= bus.frame_clk;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign tick = s2 & ~s3;
   assign pop  = tick & ~empty;

   keycode_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (Clk),
      .rst   (Reset),
      .push  (push),
      .pop   (pop),
      .din   (ev_in),
      .dout  (ev_out),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      if (pop) begin
         if (ev_out.stop) begin
            state_d = IDLE;
         end else begin
            state_d = MOVE;
            dir_d   = ev_out.dir;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         dir_q   <= UP;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         valid_q <= tick;
         if (push & full & ~pop) ovf_q <= 1'b1;
      end
   end

   assign bus.cmd_dir    = dir_q;
   assign bus.cmd_moving = (state_q == MOVE);
   assign bus.cmd_valid  = valid_q;
   assign bus.pending    = count;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_keycode_cmd.sv
// Randomised and directed check of keycode_cmd against a queue-based model.
module tb_keycode_cmd;
   localparam int S = 1024;
   localparam int D = 4;

   logic Clk = 1'b0;
   logic Reset;

   keycode_cmd_if #(.FIFO_DEPTH(D)) bus ();

   keycode_cmd #(.STABLE_CYCLES(S), .FIFO_DEPTH(D)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // -1: ignored code, 0..3: move direction, 4: stop
   function automatic int code_of(input logic [7:0] k);
      case (k)
         8'h1A:   return 0;
         8'h16:   return 1;
         8'h04:   return 2;
         8'h07:   return 3;
         8'h00:   return 4;
         default: return -1;
      endcase
   endfunction

   // Behavioural model: a code held for S consecutive samples is accepted on
   // the following edge; events sit in a queue; a vs rise seen at sample n
   // is applied at sample n+2 (two sync stages, then edge detect).
   logic [7:0] m_cand, m_acc;
   int         m_run;
   logic [2:0] m_q[$];
   logic [2:0] m_hist;
   logic [2:0] m_e;
   logic [1:0] m_dir;
   logic       m_mov, m_val, m_ovf, m_tick, m_fire;
   int         m_code;

   always @(posedge Clk) begin
      if (Reset) begin
         m_cand = 8'h00; m_acc = 8'h00; m_run = 1;
         m_q.delete();
         m_hist = 3'b111;
         m_dir = 2'd0; m_mov = 1'b0; m_val = 1'b0; m_ovf = 1'b0;
      end else begin
         m_tick = m_hist[1] && !m_hist[2];
         m_fire = (m_run >= S) && (m_cand != m_acc);
         m_val  = m_tick;
         if (m_tick && m_q.size() > 0) begin
            m_e = m_q.pop_front();
            if (m_e[2]) m_mov = 1'b0;
            else begin m_mov = 1'b1; m_dir = m_e[1:0]; end
         end
         if (m_fire) begin
            m_acc  = m_cand;
            m_code = code_of(m_cand);
            if (m_code >= 0) begin
               if (m_q.size() < D) m_q.push_back(m_code == 4 ? 3'b100 : {1'b0, m_code[1:0]});
               else m_ovf = 1'b1;
            end
         end
         if (bus.keycode != m_cand) begin m_cand = bus.keycode; m_run = 1; end
         else if (m_run < S) m_run++;
         m_hist = {m_hist[1:0], bus.frame_clk};
      end
      #1;
      chk("cmd_valid",  bus.cmd_valid,  m_val);
      chk("cmd_moving", bus.cmd_moving, m_mov);
      chk("cmd_dir",    bus.cmd_dir,    m_dir);
      chk("pending",    bus.pending,    m_q.size());
      chk("overflow",   bus.overflow,   m_ovf);
   end

   task automatic hold(input logic [7:0] k, input int n);
      @(negedge Clk) bus.keycode = k;
      repeat (n - 1) @(negedge Clk);
   endtask

   task automatic do_reset();
      @(negedge Clk) Reset = 1'b1;
      bus.keycode   = 8'h00;
      bus.frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic wait_pulse(output logic [1:0] d, output logic mv, output logic [2:0] pend,
                             output logic ovf);
      bit got = 0;
      d = 2'd0; mv = 1'b0; pend = 3'd0; ovf = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge Clk); #2;
         if (bus.cmd_valid) begin
            got = 1; d = bus.cmd_dir; mv = bus.cmd_moving; pend = bus.pending; ovf = bus.overflow;
         end
      end
      chk("cmd_valid_seen", got, 1);
   endtask

   task automatic frame(output logic [1:0] d, output logic mv);
      logic [2:0] p;
      logic       o;
      @(negedge Clk) bus.frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
      bus.frame_clk = 1'b1;
      wait_pulse(d, mv, p, o);
      repeat (3) @(negedge Clk);
   endtask

   logic [1:0] d;
   logic       mv, o;
   logic [2:0] p;
   bit         rnd_done = 0;

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not complete, got 0 expected 1");
      $fatal(1);
   end

   initial begin
      Reset = 1'b1;
      bus.keycode   = 8'h00;
      bus.frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;

      // Idle after reset: no tick, all outputs zero
      repeat (100) @(negedge Clk);
      chk("idle_valid", bus.cmd_valid, 0);
      chk("idle_dir", bus.cmd_dir, 0);
      chk("idle_moving", bus.cmd_moving, 0);
      chk("idle_pending", bus.pending, 0);

      // D held, then one frame
      hold(8'h07, 1100);
      chk("d_pending", bus.pending, 1);
      frame(d, mv);
      chk("d_dir", d, 3);
      chk("d_moving", mv, 1);
      chk("d_drained", bus.pending, 0);

      // Short glitch to W produces nothing
      do_reset();
      hold(8'h1A, 500);
      hold(8'h00, 1100);
      chk("glitch_pending", bus.pending, 0);

      // Five events into a four-deep queue
      do_reset();
      hold(8'h1A, 1100); hold(8'h00, 1100); hold(8'h04, 1100);
      hold(8'h00, 1100); hold(8'h16, 1100);
      chk("ovf_pending", bus.pending, 4);
      chk("ovf_flag", bus.overflow, 1);
      frame(d, mv); chk("f1_dir", d, 0); chk("f1_mov", mv, 1);
      frame(d, mv); chk("f2_dir", d, 0); chk("f2_mov", mv, 0);
      frame(d, mv); chk("f3_dir", d, 2); chk("f3_mov", mv, 1);
      frame(d, mv); chk("f4_dir", d, 2); chk("f4_mov", mv, 0);
      chk("ovf_empty", bus.pending, 0);

      // Full queue, push and tick on the same edge
      do_reset();
      hold(8'h1A, 1100); hold(8'h00, 1100); hold(8'h04, 1100); hold(8'h00, 1100);
      chk("full_pending", bus.pending, 4);
      @(negedge Clk);
      bus.keycode   = 8'h07;
      bus.frame_clk = 1'b0;
      repeat (S - 2) @(negedge Clk);
      bus.frame_clk = 1'b1;
      wait_pulse(d, mv, p, o);
      chk("same_pending", p, 4);
      chk("same_ovf", o, 0);
      chk("same_dir", d, 0);
      repeat (3) @(negedge Clk);
      frame(d, mv); frame(d, mv); frame(d, mv); frame(d, mv);
      chk("same_last_dir", d, 3);
      chk("same_last_mov", mv, 1);

      // Reset mid-run clears queue and motion
      do_reset();
      hold(8'h07, 1100); hold(8'h00, 1100); hold(8'h04, 1100); hold(8'h00, 1100);
      frame(d, mv);
      chk("pre_rst_pending", bus.pending, 3);
      chk("pre_rst_moving", bus.cmd_moving, 1);
      do_reset();
      chk("rst_pending", bus.pending, 0);
      chk("rst_moving", bus.cmd_moving, 0);
      frame(d, mv);
      chk("post_rst_mov", mv, 0);

      // Random keycodes with free-running frames
      fork
         begin
            logic [7:0] pick [7];
            logic [7:0] k;
            pick[0] = 8'h00; pick[1] = 8'h1A; pick[2] = 8'h04; pick[3] = 8'h16;
            pick[4] = 8'h07; pick[5] = 8'h05; pick[6] = 8'h2C;
            for (int i = 0; i < 40; i++) begin
               k = pick[$urandom_range(0, 6)];
               hold(k, ($urandom_range(0, 3) == 0) ? $urandom_range(1, S - 1)
                                                   : $urandom_range(S, 1600));
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               repeat ($urandom_range(200, 900)) @(negedge Clk);
               bus.frame_clk = 1'b0;
               repeat ($urandom_range(1, 4)) @(negedge Clk);
               bus.frame_clk = 1'b1;
            end
         end
      join
      repeat (10) @(negedge Clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
